// File: rtl/dmem_pkg.sv
// Shared FSM type, counter width and address-to-word-index helper for dmem_slave.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // Word offset from the window base, wrapped to the array size.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned depth_w);
    logic [63:0] off;
    off = addr - base;
    return (off >> 2) & ((64'd1 << depth_w) - 64'd1);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-writable word array with per-lane write enables and a registered read port.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH_W = 10
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [XLEN/8-1:0]    be,
  input  logic [DEPTH_W-1:0]   addr,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      rdata
);

  localparam int LANES = XLEN / 8;

  logic [XLEN-1:0] mem [2**DEPTH_W];

  // Contents are deliberately never reset; rdata holds until the next read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_slave.sv
// Data-memory responder: one request at a time, fixed LATENCY, response held under back-pressure.
// Optional address window check enabled by defining DMEM_ERR_CHECK_EN.
module dmem_slave
  import dmem_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH_W   = 10,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'h8000_0000),
  parameter int              LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN/8-1:0] req_wstrb,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int LANES = XLEN / 8;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               wen_q;
  logic               err_q;
  logic               accept;
  logic               oow;
  logic [DEPTH_W-1:0] idx;
  logic [LANES-1:0]   be;
  logic [XLEN-1:0]    ram_rdata;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && !rst;
  assign idx       = DEPTH_W'(word_index(64'(req_addr), 64'(BASE_ADDR), DEPTH_W));

`ifdef DMEM_ERR_CHECK_EN
  localparam logic [63:0] WIN_END = 64'(BASE_ADDR) + (64'd4 << DEPTH_W);
  assign oow = (64'(req_addr) < 64'(BASE_ADDR)) || (64'(req_addr) >= WIN_END);
`else
  assign oow = 1'b0;
`endif

  // Writes commit and reads sample on the accept edge itself.
  assign be = (accept && req_wen && !oow) ? req_wstrb : '0;

  dmem_ram #(
    .XLEN    (XLEN),
    .DEPTH_W (DEPTH_W)
  ) u_ram (
    .clk   (clk),
    .re    (accept && !req_wen),
    .be    (be),
    .addr  (idx),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  // Counter loads LATENCY-1 and RESP is entered as it steps down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      wen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wen_q <= req_wen;
            err_q <= oow;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !wen_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_slave.sv
// Self-checking bench for dmem_slave: directed cases, random traffic against a word/byte model, latency sweep.
module tb_dmem_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT  = 2;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        s_req_valid;
  logic [1:0]  s_rdy, s_vld, s_err;
  logic [31:0] s_rdata [2];

  always #5 clk = ~clk;

  dmem_slave #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_slave #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_rdy[0]),
    .req_wen(1'b0), .req_addr(BASE), .req_wstrb(4'h0), .req_wdata(32'h0),
    .rsp_valid(s_vld[0]), .rsp_ready(1'b1), .rsp_rdata(s_rdata[0]), .rsp_err(s_err[0])
  );

  dmem_slave #(.LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_rdy[1]),
    .req_wen(1'b0), .req_addr(BASE), .req_wstrb(4'h0), .req_wdata(32'h0),
    .rsp_valid(s_vld[1]), .rsp_ready(1'b1), .rsp_rdata(s_rdata[1]), .rsp_err(s_err[1])
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] ref_mem   [1024];
  logic [3:0]  ref_known [1024];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ({32'h0, a} < ({32'h0, BASE} + 64'd4096));
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[11:2];
  endfunction

  // One full transaction with model prediction, latency, hold and release checks.
  task automatic txn(input bit wen, input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input int hold, output logic [31:0] rdata);
    int          n;
    bit          err_exp;
    logic [31:0] exp_d, mask;
    logic [9:0]  ix;
    ix      = widx(addr);
    err_exp = ERRCHK && !in_win(addr);
    if (wen || err_exp) begin
      exp_d = 32'h0;
      mask  = 32'hFFFF_FFFF;
    end else begin
      exp_d = ref_mem[ix];
      for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{ref_known[ix][i]}};
    end
    if (wen && !err_exp) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          ref_mem[ix][i*8 +: 8] = wdata[i*8 +: 8];
          ref_known[ix][i]      = 1'b1;
        end
      end
    end
    rdata = 32'h0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", req_ready, 1);
    req_wen = wen; req_addr = addr; req_wstrb = wstrb; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rsp_valid) chk("busy_req_ready", req_ready, 0);
    end while (!rsp_valid && n < 40);
    chk("latency", n, LAT);
    if (!rsp_valid) return;
    chk("rsp_rdata", rsp_rdata & mask, exp_d & mask);
    chk("rsp_err", rsp_err, err_exp);
    rdata = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata & mask, exp_d & mask);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("release_valid", rsp_valid, 0);
    chk("release_req_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          last [2];
    bit          pend [2];
    int          acc  [2];
    int          lat_tab [2];

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
    req_wstrb = 4'h0; req_wdata = 32'h0; rsp_ready = 1'b0; s_req_valid = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ref_known[i] = 4'h0;
      ref_mem[i]   = 32'h0;
    end

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);

    txn(1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 0, rd);
    txn(1'b0, 32'h8000_0010, 4'h0, 32'h0, 0, rd);
    chk("write_read", rd, 32'hDEAD_BEEF);
    txn(1'b1, 32'h8000_0010, 4'h5, 32'h1122_3344, 0, rd);
    txn(1'b0, 32'h8000_0010, 4'h0, 32'h0, 5, rd);
    chk("partial_strobe", rd, 32'hDE22_BE44);
    txn(1'b1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 0, rd);
    txn(1'b0, 32'h8000_0010, 4'h0, 32'h0, 0, rd);
    chk("zero_strobe", rd, 32'hDE22_BE44);

    txn(1'b1, 32'h8000_0FFC, 4'hF, 32'h0102_0304, 0, rd);
    txn(1'b1, 32'h8000_0000, 4'hF, 32'hCAFE_F00D, 1, rd);
    txn(1'b1, 32'h7FFF_FFFC, 4'hF, 32'hFFFF_FFFF, 0, rd);
    txn(1'b0, 32'h8000_0FFC, 4'h0, 32'h0, 0, rd);
    chk("below_window_write", rd, ERRCHK ? 32'h0102_0304 : 32'hFFFF_FFFF);
    txn(1'b0, 32'h8000_1000, 4'h0, 32'h0, 2, rd);
    chk("above_window_read", rd, ERRCHK ? 32'h0 : 32'hCAFE_F00D);

    txn(1'b1, 32'h8000_0020, 4'hF, 32'h5A5A_A5A5, 0, rd);
    req_wen = 1'b0; req_addr = 32'h8000_0020; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("midop_in_wait", req_ready, 0);
    rst = 1'b1;
    #1;
    chk("midop_rst_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midop_after_ready", req_ready, 1);
    chk("midop_after_valid", rsp_valid, 0);
    txn(1'b0, 32'h8000_0020, 4'h0, 32'h0, 0, rd);
    chk("midop_write_kept", rd, 32'h5A5A_A5A5);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = BASE + 32'(4 * $urandom_range(0, 15));
      else if (sel == 8) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 3));
      else               a = BASE - 32'(4 * $urandom_range(1, 4));
      txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, $urandom_range(0, 3), rd);
    end

    lat_tab[0] = 1;
    lat_tab[1] = 15;
    for (int i = 0; i < 2; i++) begin
      last[i] = -1;
      pend[i] = 1'b0;
      acc[i]  = 0;
    end
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 0) s_req_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (s_vld[i]) begin
          if (pend[i]) begin
            chk($sformatf("sweep_latency_l%0d", lat_tab[i]), c - last[i], lat_tab[i]);
            pend[i] = 1'b0;
          end else begin
            chk($sformatf("sweep_extra_valid_l%0d", lat_tab[i]), s_vld[i], 0);
          end
        end
        if (s_rdy[i]) begin
          if (last[i] >= 0)
            chk($sformatf("sweep_period_l%0d", lat_tab[i]), c - last[i], lat_tab[i] + 1);
          last[i] = c;
          pend[i] = 1'b1;
          acc[i]++;
        end
      end
    end
    s_req_valid = 1'b0;
    chk("sweep_accepts_l1", acc[0] >= 39, 1);
    chk("sweep_accepts_l15", acc[1] >= 5, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
